cdb_result_buffer: RTL and testbench

CDB_RESULT_BUFFER -- requirements
Module: cdb_result_buffer

---
 rtl/cdb_pkg.sv | 17 +
 rtl/cdb_result_buffer.sv | 97 +++++++++
 tb/tb_cdb_result_buffer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_pkg.sv
// Shared CDB definitions used by every result producer on the common data bus.
`default_nettype none

package cdb_pkg;

  localparam int CDB_DATA_WIDTH = 32;
  localparam int CDB_TAG_WIDTH  = 5;

  typedef struct packed {
    logic [CDB_DATA_WIDTH-1:0] data;
    logic [CDB_TAG_WIDTH-1:0]  tag;
    logic                      exception;
  } cdb_result_t;

endpackage

`default_nettype wire

// File: rtl/cdb_result_buffer.sv
// In-order result FIFO between a functional unit and a CDB channel.
// Optional same-cycle empty-buffer bypass: define CDB_RESULT_BUFFER_BYPASS_EN.
`default_nettype none

module cdb_result_buffer
  import cdb_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int TAG_WIDTH = CDB_TAG_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fu_valid,
  output logic                     fu_ready,
  input  logic [31:0]              fu_data,
  input  logic [TAG_WIDTH-1:0]     fu_tag,
  input  logic                     fu_exception,
  input  logic                     flush,
  output logic                     cdb_req,
  input  logic                     cdb_grant,
  output logic [31:0]              cdb_data,
  output logic [TAG_WIDTH-1:0]     cdb_tag,
  output logic                     cdb_exception,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  cdb_result_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] occ;

  cdb_result_t fu_entry;
  cdb_result_t head_entry;
  cdb_result_t out_entry;
  logic        push;
  logic        pop;

  assign fu_entry   = '{data: fu_data, tag: fu_tag, exception: fu_exception};
  assign head_entry = mem[rd_ptr];

  // Ready depends only on registered occupancy, never on this cycle's grant.
  assign fu_ready = (occ < FULL_COUNT);
  assign pop      = cdb_grant && (occ != '0) && !flush;

`ifdef CDB_RESULT_BUFFER_BYPASS_EN
  logic bypass_hit;

  assign bypass_hit = (occ == '0) && fu_valid && !flush;
  assign cdb_req    = (occ != '0) || bypass_hit;
  assign out_entry  = bypass_hit ? fu_entry : head_entry;
  // A granted bypass result has already reached the bus, so it is not stored.
  assign push       = fu_valid && fu_ready && !flush && !(bypass_hit && cdb_grant);
`else
  assign cdb_req    = (occ != '0);
  assign out_entry  = head_entry;
  assign push       = fu_valid && fu_ready && !flush;
`endif

  assign cdb_data      = cdb_req ? out_entry.data      : '0;
  assign cdb_tag       = cdb_req ? out_entry.tag       : '0;
  assign cdb_exception = cdb_req ? out_entry.exception : 1'b0;
  assign count         = occ;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      occ <= occ + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage carries no reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= fu_entry;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cdb_result_buffer.sv
// Directed self-checking bench for cdb_result_buffer (DEPTH 4, TAG_WIDTH 5).
`default_nettype none

module tb_cdb_result_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fu_valid;
  logic        fu_ready;
  logic [31:0] fu_data;
  logic [4:0]  fu_tag;
  logic        fu_exception;
  logic        flush;
  logic        cdb_req;
  logic        cdb_grant;
  logic [31:0] cdb_data;
  logic [4:0]  cdb_tag;
  logic        cdb_exception;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cdb_result_buffer #(.DEPTH(4), .TAG_WIDTH(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fu_valid      (fu_valid),
    .fu_ready      (fu_ready),
    .fu_data       (fu_data),
    .fu_tag        (fu_tag),
    .fu_exception  (fu_exception),
    .flush         (flush),
    .cdb_req       (cdb_req),
    .cdb_grant     (cdb_grant),
    .cdb_data      (cdb_data),
    .cdb_tag       (cdb_tag),
    .cdb_exception (cdb_exception),
    .count         (count)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fu(input logic v, input logic [31:0] d, input logic [4:0] t, input logic e);
    fu_valid     = v;
    fu_data      = d;
    fu_tag       = t;
    fu_exception = e;
  endtask

  initial begin
    int exp_pop;
    int next_tag;
    int cycles;

    rst_n = 1'b0;
    flush = 1'b0;
    cdb_grant = 1'b0;
    drive_fu(1'b0, 32'h0, 5'd0, 1'b0);
    tick();
    tick();
    // Activity while reset is held must be ignored.
    drive_fu(1'b1, 32'hCAFE0000, 5'd9, 1'b1);
    cdb_grant = 1'b1;
    flush = 1'b1;
    tick();
    drive_fu(1'b0, 32'h0, 5'd0, 1'b0);
    cdb_grant = 1'b0;
    flush = 1'b0;
    rst_n = 1'b1;
    #1;
    check_val("reset_count", 32'(count), 32'd0);
    check_val("reset_req", 32'(cdb_req), 32'd0);
    check_val("reset_ready", 32'(fu_ready), 32'd1);
    check_val("reset_data", cdb_data, 32'd0);
    check_val("reset_tag", 32'(cdb_tag), 32'd0);
    check_val("reset_exc", 32'(cdb_exception), 32'd0);

    // Single push, no grant.
    drive_fu(1'b1, 32'hDEADBEEF, 5'd3, 1'b0);
`ifndef CDB_RESULT_BUFFER_BYPASS_EN
    #1;
    check_val("nobypass_req_same_cycle", 32'(cdb_req), 32'd0);
`endif
    tick();
    drive_fu(1'b0, 32'h0, 5'd0, 1'b0);
    check_val("push1_req", 32'(cdb_req), 32'd1);
    check_val("push1_data", cdb_data, 32'hDEADBEEF);
    check_val("push1_tag", 32'(cdb_tag), 32'd3);
    check_val("push1_count", 32'(count), 32'd1);
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
    check_val("pop1_count", 32'(count), 32'd0);
    check_val("pop1_data_zero", cdb_data, 32'd0);

    // Fill to DEPTH, then present a fifth result that must be dropped.
    for (int i = 0; i < 4; i++) begin
      drive_fu(1'b1, 32'h100 + 32'(i), 5'(10 + i), (i == 2));
      tick();
    end
    check_val("full_count", 32'(count), 32'd4);
    check_val("full_ready", 32'(fu_ready), 32'd0);
    drive_fu(1'b1, 32'h999, 5'd31, 1'b0);
    tick();
    check_val("drop_count", 32'(count), 32'd4);
    check_val("drop_head", cdb_data, 32'h100);
    check_val("drop_tag", 32'(cdb_tag), 32'd10);

    // Full: grant with a held push pops only; the held result lands next cycle.
    drive_fu(1'b1, 32'h200, 5'd20, 1'b0);
    cdb_grant = 1'b1;
    #1;
    check_val("full_grant_ready", 32'(fu_ready), 32'd0);
    tick();
    cdb_grant = 1'b0;
    check_val("full_grant_count", 32'(count), 32'd3);
    check_val("full_grant_head", cdb_data, 32'h101);
    tick();
    drive_fu(1'b0, 32'h0, 5'd0, 1'b0);
    check_val("refill_count", 32'(count), 32'd4);
    check_val("refill_head_tag", 32'(cdb_tag), 32'd11);

    // Pop down to DEPTH-1, then simultaneous push and pop there.
    cdb_grant = 1'b1;
    tick();
    check_val("pop_to3_count", 32'(count), 32'd3);
    check_val("pop_to3_exc", 32'(cdb_exception), 32'd1);
    drive_fu(1'b1, 32'h300, 5'd21, 1'b0);
    tick();
    drive_fu(1'b0, 32'h0, 5'd0, 1'b0);
    cdb_grant = 1'b0;
    check_val("pushpop_count", 32'(count), 32'd3);
    check_val("pushpop_head", cdb_data, 32'h103);
    check_val("pushpop_exc", 32'(cdb_exception), 32'd0);

    // Flush with push and grant: the bus still sees the head this cycle.
    flush = 1'b1;
    cdb_grant = 1'b1;
    drive_fu(1'b1, 32'h400, 5'd22, 1'b0);
    #1;
    check_val("flush_cycle_req", 32'(cdb_req), 32'd1);
    check_val("flush_cycle_data", cdb_data, 32'h103);
    tick();
    flush = 1'b0;
    cdb_grant = 1'b0;
    drive_fu(1'b0, 32'h0, 5'd0, 1'b0);
    check_val("flush_count", 32'(count), 32'd0);
    check_val("flush_req", 32'(cdb_req), 32'd0);
    check_val("flush_ready", 32'(fu_ready), 32'd1);

    // Tags 1..8 with random grants, wrapping the pointers twice.
    exp_pop = 1;
    next_tag = 1;
    cycles = 0;
    while (exp_pop <= 8 && cycles < 200) begin
      if (next_tag <= 8) drive_fu(1'b1, 32'hA000 + 32'(next_tag), 5'(next_tag), 1'b0);
      else drive_fu(1'b0, 32'h0, 5'd0, 1'b0);
      cdb_grant = 1'($urandom_range(0, 1));
      #1;
      if (cdb_req && cdb_grant) begin
        check_val("order_tag", 32'(cdb_tag), 32'(exp_pop));
        check_val("order_data", cdb_data, 32'hA000 + 32'(exp_pop));
        exp_pop++;
      end
      if (fu_valid && fu_ready) next_tag++;
      tick();
      cycles++;
    end
    drive_fu(1'b0, 32'h0, 5'd0, 1'b0);
    cdb_grant = 1'b0;
    #1;
    check_val("order_all_popped", 32'(exp_pop), 32'd9);
    check_val("order_end_count", 32'(count), 32'd0);

`ifdef CDB_RESULT_BUFFER_BYPASS_EN
    drive_fu(1'b1, 32'h12345678, 5'd7, 1'b0);
    cdb_grant = 1'b1;
    #1;
    check_val("bypass_req", 32'(cdb_req), 32'd1);
    check_val("bypass_data", cdb_data, 32'h12345678);
    check_val("bypass_tag", 32'(cdb_tag), 32'd7);
    tick();
    drive_fu(1'b0, 32'h0, 5'd0, 1'b0);
    cdb_grant = 1'b0;
    check_val("bypass_count", 32'(count), 32'd0);
    check_val("bypass_req_after", 32'(cdb_req), 32'd0);
`else
    // Empty buffer: no same-cycle path, and a grant without request is ignored.
    drive_fu(1'b1, 32'h12345678, 5'd7, 1'b0);
    cdb_grant = 1'b1;
    #1;
    check_val("nobypass_req", 32'(cdb_req), 32'd0);
    check_val("nobypass_data", cdb_data, 32'd0);
    tick();
    drive_fu(1'b0, 32'h0, 5'd0, 1'b0);
    cdb_grant = 1'b0;
    check_val("nobypass_count", 32'(count), 32'd1);
    check_val("nobypass_head", cdb_data, 32'h12345678);
    check_val("nobypass_tag", 32'(cdb_tag), 32'd7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
